lif_receiver: RTL and testbench

Postsynaptic leaky integrate-and-fire receiver. It sits at the output end of the synapse stage and accepts delayed spike levels from N_SYN synapses. It integrates per-synapse weights on each rising edge into a leaking membrane potential, and emits a one-cycle output spike when the threshold is reached. After each spike it enforces a fixed refractory period and counts fired spikes.

---
 rtl/lif_receiver.sv | 107 ++++++++++
 tb/tb_lif_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lif_receiver.sv
// Leaky integrate-and-fire receiver: integrates rising-edge-weighted synaptic
// inputs into a leaking membrane, fires a one-cycle spike, then goes refractory.
module lif_receiver #(
    parameter int N_SYN      = 4,
    parameter int W          = 8,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SYN-1:0]   syn_in,
    input  logic [8*N_SYN-1:0] syn_weight,
    output logic               spike_out,
    output logic [W-1:0]       membrane,
    output logic               refractory,
    output logic [7:0]         spike_count
);

    localparam int SW  = W + $clog2(N_SYN) + 8;
    localparam int RCW = (REFRAC > 1) ? $clog2(REFRAC) : 1;

    localparam logic [0:0] ST_INTEGRATE  = 1'b0;
    localparam logic [0:0] ST_REFRACTORY = 1'b1;

    logic [W-1:0]     v_q, v_d;
    logic [N_SYN-1:0] prev_q;
    logic [0:0]       state_q, state_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             spike_q, spike_d;
    logic [7:0]       count_q, count_d;

    logic [SW-1:0]    term [N_SYN];
    logic [SW-1:0]    edge_sum;
    logic [SW-1:0]    sum;
    logic [W-1:0]     shifted;
    logic [W-1:0]     leak;
    logic             can_integrate;

    genvar gi;
    generate
        for (gi = 0; gi < N_SYN; gi++) begin : g_term
            assign term[gi] = (syn_in[gi] & ~prev_q[gi]) ? SW'(syn_weight[8*gi +: 8]) : '0;
        end
    endgenerate

    // Leak has a floor of 1 so small potentials still decay all the way to 0.
    assign shifted = v_q >> LEAK_SHIFT;
    assign leak    = (shifted != '0) ? shifted : ((v_q != '0) ? W'(1) : '0);

    // The last refractory cycle (rcnt == 0) already integrates that cycle's edges.
    assign can_integrate = (state_q == ST_INTEGRATE) || (rcnt_q == '0);

    always_comb begin
        edge_sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            edge_sum = edge_sum + term[i];
        end
        sum = SW'(v_q) - SW'(leak) + edge_sum;

        v_d     = v_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        spike_d = 1'b0;
        count_d = count_q;

        if (can_integrate) begin
            if (sum >= SW'(THRESH)) begin
                v_d     = '0;
                spike_d = 1'b1;
                count_d = count_q + 8'd1;
                rcnt_d  = RCW'(REFRAC - 1);
                state_d = ST_REFRACTORY;
            end else begin
                v_d     = sum[W-1:0];
                state_d = ST_INTEGRATE;
            end
        end else begin
            v_d    = '0;
            rcnt_d = rcnt_q - RCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= '0;
            prev_q  <= '0;
            state_q <= ST_INTEGRATE;
            rcnt_q  <= '0;
            spike_q <= 1'b0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            prev_q  <= syn_in;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            spike_q <= spike_d;
            count_q <= count_d;
        end
    end

    assign spike_out   = spike_q;
    assign membrane    = v_q;
    assign refractory  = (state_q == ST_REFRACTORY);
    assign spike_count = count_q;

endmodule

// File: tb/tb_lif_receiver.sv
// Directed bench for lif_receiver: default instance plus a REFRAC=1 instance
// for the spike-count wrap sequence.
module tb_lif_receiver;

    logic       clk;
    logic       reset;
    logic [3:0] syn_a, syn_b;
    logic [31:0] w_a, w_b;
    logic       spike_a, spike_b;
    logic [7:0] mem_a, mem_b;
    logic       ref_a, ref_b;
    logic [7:0] cnt_a, cnt_b;

    int checks;
    int errors;

    lif_receiver u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .syn_in      (syn_a),
        .syn_weight  (w_a),
        .spike_out   (spike_a),
        .membrane    (mem_a),
        .refractory  (ref_a),
        .spike_count (cnt_a)
    );

    lif_receiver #(.REFRAC(1)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .syn_in      (syn_b),
        .syn_weight  (w_b),
        .spike_out   (spike_b),
        .membrane    (mem_b),
        .refractory  (ref_b),
        .spike_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int exp1[5] = '{40, 35, 31, 28, 25};
    int exp4[7] = '{5, 4, 3, 2, 1, 0, 0};

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        syn_a  = '0;
        syn_b  = '0;
        w_a    = {4{8'd40}};
        w_b    = {4{8'd255}};

        do_reset();
        check("rst_spike", 32'(spike_a), 0);
        check("rst_mem", 32'(mem_a), 0);
        check("rst_refr", 32'(ref_a), 0);
        check("rst_count", 32'(cnt_a), 0);

        // One edge then held high: weight added once, then leak only.
        syn_a = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("leak40_mem[%0d]", i), 32'(mem_a), 32'(exp1[i]));
            check($sformatf("leak40_spk[%0d]", i), 32'(spike_a), 0);
        end

        // Simultaneous edges on all four inputs fire.
        syn_a = 4'b0000;
        w_a   = {4{8'd60}};
        do_reset();
        tick();
        syn_a = 4'b1111;
        tick();
        check("fire_spike", 32'(spike_a), 1);
        check("fire_mem", 32'(mem_a), 0);
        check("fire_refr", 32'(ref_a), 1);
        check("fire_count", 32'(cnt_a), 1);
        syn_a = 4'b0000;
        tick();
        check("k1_spike", 32'(spike_a), 0);
        check("k1_refr", 32'(ref_a), 1);
        syn_a = 4'b0010;
        tick();
        check("k2_mem_ignored", 32'(mem_a), 0);
        check("k2_refr", 32'(ref_a), 1);
        check("k2_spike", 32'(spike_a), 0);
        syn_a = 4'b0000;
        tick();
        check("k3_refr", 32'(ref_a), 1);
        check("k3_mem", 32'(mem_a), 0);
        syn_a = 4'b0010;
        tick();
        check("k4_mem", 32'(mem_a), 60);
        check("k4_refr", 32'(ref_a), 0);
        check("k4_spike", 32'(spike_a), 0);
        check("k4_count", 32'(cnt_a), 1);

        // Small weight: floor leak walks down to 0 and stays.
        syn_a = 4'b0000;
        w_a   = {8'd0, 8'd0, 8'd0, 8'd5};
        do_reset();
        tick();
        syn_a = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("floor_mem[%0d]", i), 32'(mem_a), 32'(exp4[i]));
        end

        // REFRAC=1 instance: a spike every 2 cycles, count wraps after 256.
        for (int i = 0; i < 256; i++) begin
            syn_b = 4'b0001;
            tick();
            check($sformatf("wrap_spk[%0d]", i), 32'(spike_b), 1);
            check($sformatf("wrap_cnt[%0d]", i), 32'(cnt_b), 32'((i + 1) % 256));
            syn_b = 4'b0000;
            tick();
            check($sformatf("wrap_gap[%0d]", i), 32'(spike_b), 0);
            check($sformatf("wrap_ref[%0d]", i), 32'(ref_b), 0);
        end
        check("wrap_final", 32'(cnt_b), 0);
        syn_b = 4'b0001;
        tick();
        check("wrap_plus1", 32'(cnt_b), 1);
        syn_b = 4'b0000;

        // Reset in refractory cycle 2 clears everything; held input re-edges.
        syn_a = 4'b0000;
        w_a   = {4{8'd60}};
        do_reset();
        tick();
        syn_a = 4'b1111;
        tick();
        check("pre_rst_refr", 32'(ref_a), 1);
        syn_a = 4'b0001;
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_spike", 32'(spike_a), 0);
        check("mid_rst_mem", 32'(mem_a), 0);
        check("mid_rst_refr", 32'(ref_a), 0);
        check("mid_rst_count", 32'(cnt_a), 0);
        check("mid_rst_count_b", 32'(cnt_b), 0);
        reset = 1'b0;
        tick();
        check("post_rst_edge_mem", 32'(mem_a), 60);
        check("post_rst_spike", 32'(spike_a), 0);
        tick();
        check("post_rst_held_mem", 32'(mem_a), 53);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
